cgra_obi_col_arbiter: RTL

Funnels the four CGRA column OBI master ports onto the single external-crossbar master path toward the CGRA context-memory/bus slave window. It arbitrates requests round-robin and holds a locked selection until grant, as OBI requires. It records the granted column of every outstanding transaction in an in-order ID FIFO and routes each `rvalid`/`rdata` back to the column that issued it. It sits between the CGRA column load/store units and the external crossbar master port.

---
 rtl/cgra_obi_col_arbiter_if.sv | 44 ++++
 rtl/cgra_obi_col_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cgra_obi_col_arbiter_if.sv
// ---------------------------------------------------------------------------
// cgra_obi_col_arbiter_if
// Groups the CGRA column OBI master ports and the single crossbar master
// path used by cgra_obi_col_arbiter.
//   col_*_i / col_*_o : per-column request fields (flat, column k at slice k)
//                       and per-column grant / response
//   bus_*_o / bus_*_i : forwarded request and downstream handshake/response
// Modport slave is the arbiter's view; modport master is its environment's.
// ---------------------------------------------------------------------------
interface cgra_obi_col_arbiter_if #(
   parameter int unsigned N_MASTER = 4
);
   logic [N_MASTER-1:0]    col_req_i;
   logic [N_MASTER-1:0]    col_we_i;
   logic [4*N_MASTER-1:0]  col_be_i;
   logic [32*N_MASTER-1:0] col_addr_i;
   logic [32*N_MASTER-1:0] col_wdata_i;
   logic [N_MASTER-1:0]    col_gnt_o;
   logic [N_MASTER-1:0]    col_rvalid_o;
   logic [32*N_MASTER-1:0] col_rdata_o;

   logic                   bus_req_o;
   logic                   bus_we_o;
   logic [3:0]             bus_be_o;
   logic [31:0]            bus_addr_o;
   logic [31:0]            bus_wdata_o;
   logic                   bus_gnt_i;
   logic                   bus_rvalid_i;
   logic [31:0]            bus_rdata_i;

   modport slave (
      input  col_req_i, col_we_i, col_be_i, col_addr_i, col_wdata_i,
      output col_gnt_o, col_rvalid_o, col_rdata_o,
      output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
      input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
   );

   modport master (
      output col_req_i, col_we_i, col_be_i, col_addr_i, col_wdata_i,
      input  col_gnt_o, col_rvalid_o, col_rdata_o,
      input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
      output bus_gnt_i, bus_rvalid_i, bus_rdata_i
   );
endinterface

// File: rtl/cgra_obi_col_arbiter.sv
// ---------------------------------------------------------------------------
// cgra_obi_col_arbiter
// Round-robin arbiter funnelling N_MASTER CGRA column OBI masters onto one
// crossbar master path. A selection that has been presented without grant
// stays locked until granted. Granted column IDs are kept in an in-order
// FIFO so each response is routed back to the column that issued it.
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : synchronous active-low reset
//   obi            : column and bus handshake signals (slave modport)
//   err_o          : sticky, response arrived with no outstanding ID
//   outstanding_o  : ID FIFO occupancy
// ---------------------------------------------------------------------------
module cgra_obi_col_arbiter #(
   parameter int unsigned N_MASTER        = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   cgra_obi_col_arbiter_if.slave                 obi,
   output logic                                  err_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o
);
   localparam int unsigned IDX_W = $clog2(N_MASTER);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOCKED,
      ST_FULL
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_lock_idx;
   logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   logic             w_locked;
   logic             w_full;
   logic             w_found;
   logic [IDX_W-1:0] w_sel;
   logic             w_sel_req;
   logic             w_bus_req;
   logic             w_hs;
   logic             w_lock_set;
   logic             w_pop;
   logic             w_spurious;
   logic [IDX_W-1:0] w_head;
   logic [CNT_W-1:0] w_count_nxt;
   state_t           w_state_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_locked   = (r_state == ST_LOCKED);
   assign w_full     = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_head     = r_fifo[r_rd_ptr];
   assign w_pop      = obi.bus_rvalid_i && (r_count != '0);
   assign w_spurious = obi.bus_rvalid_i && (r_count == '0);

   // Selection: locked index, else nearest requester at or after r_ptr (circular distance)
   always_comb begin
      int unsigned v_dist;
      int unsigned v_best;
      w_sel   = r_ptr;
      w_found = 1'b0;
      v_dist  = 0;
      v_best  = N_MASTER;
      if (w_locked) begin
         w_sel   = r_lock_idx;
         w_found = 1'b1;
      end else begin
         for (int unsigned k = 0; k < N_MASTER; k++) begin
            v_dist = (k >= 32'(r_ptr)) ? (k - 32'(r_ptr)) : (k + N_MASTER - 32'(r_ptr));
            if (obi.col_req_i[k] && (v_dist < v_best)) begin
               v_best  = v_dist;
               w_sel   = IDX_W'(k);
               w_found = 1'b1;
            end
         end
      end
   end

   // Request bit of the selected column (a locked column may have dropped it)
   always_comb begin
      w_sel_req = 1'b0;
      for (int unsigned k = 0; k < N_MASTER; k++) begin
         if (w_sel == IDX_W'(k)) begin
            w_sel_req = obi.col_req_i[k];
         end
      end
   end

   // A full FIFO gates the request even when a pop happens this cycle
   assign w_bus_req  = w_found && w_sel_req && !w_full;
   assign w_hs       = w_bus_req && obi.bus_gnt_i;
   assign w_lock_set = w_bus_req && !obi.bus_gnt_i;

   // Forwarded request fields, zero while no request is presented
   always_comb begin
      obi.bus_req_o   = w_bus_req;
      obi.bus_we_o    = 1'b0;
      obi.bus_be_o    = '0;
      obi.bus_addr_o  = '0;
      obi.bus_wdata_o = '0;
      obi.col_gnt_o   = '0;
      for (int unsigned k = 0; k < N_MASTER; k++) begin
         if (w_bus_req && (w_sel == IDX_W'(k))) begin
            obi.bus_we_o    = obi.col_we_i[k];
            obi.bus_be_o    = obi.col_be_i[k*4 +: 4];
            obi.bus_addr_o  = obi.col_addr_i[k*32 +: 32];
            obi.bus_wdata_o = obi.col_wdata_i[k*32 +: 32];
            obi.col_gnt_o[k] = obi.bus_gnt_i;
         end
      end
   end

   // Response routing to the column at the FIFO head
   always_comb begin
      obi.col_rvalid_o = '0;
      obi.col_rdata_o  = '0;
      for (int unsigned k = 0; k < N_MASTER; k++) begin
         if (w_pop && (w_head == IDX_W'(k))) begin
            obi.col_rvalid_o[k]          = 1'b1;
            obi.col_rdata_o[k*32 +: 32]  = obi.bus_rdata_i;
         end
      end
   end

   // Occupancy and arbitration state for the next cycle
   always_comb begin
      w_count_nxt = r_count;
      if (w_hs && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_hs && w_pop) begin
         w_count_nxt = r_count - 1'b1;
      end
      if (w_lock_set) begin
         w_state_nxt = ST_LOCKED;
      end else if (w_count_nxt == CNT_W'(MAX_OUTSTANDING)) begin
         w_state_nxt = ST_FULL;
      end else if (w_count_nxt == '0) begin
         w_state_nxt = ST_IDLE;
      end else begin
         w_state_nxt = ST_ARB;
      end
   end

   // Arbitration state, ID FIFO and error flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_lock_idx <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
         for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
            r_fifo[k] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_lock_set) begin
            r_lock_idx <= w_sel;
         end
         if (w_hs) begin
            r_fifo[r_wr_ptr] <= w_sel;
            r_wr_ptr         <= ptr_inc(r_wr_ptr);
            r_ptr            <= (w_sel == IDX_W'(N_MASTER - 1)) ? '0 : w_sel + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_spurious) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err_o         = r_err;
   assign outstanding_o = r_count;
endmodule
